instr_decode_stage: RTL
=======================

// Module: instr_decode_stage
// PURPOSE
//  Registered RV32/RV64 base-ISA decode stage between fetch and register read.
//  Splits each instruction into its fields and generates the sign-extended
//  immediate for every format. Classifies the format, flags illegal opcodes and
//  reports register usage. Valid/ready on both sides; flush kills the held entry.
//  Successor of the combinational field splitter: adds width generality,
//  immediates, handshake, flush and event counters.
// PARAMETERS
//  XLEN     32  datapath width; immediates are sign-extended to XLEN (32 or 64)
//  PC_W     32  width of the PC carried alongside the instruction
//  CNT_W    16  width of the saturating decode/illegal counters
// PORTS
//  clk          in   1      clock; all state updates on the rising edge
//  rst_n        in   1      synchronous active-low reset
//  flush        in   1      discard the held entry (branch redirect/trap)
//  in_valid     in   1      upstream instruction valid
//  in_ready     out  1      stage can accept this cycle
//  in_instr     in   32     instruction word
//  in_pc        in   PC_W   PC of in_instr
//  out_valid    out  1      decoded entry valid
//  out_ready    in   1      downstream accepts the entry
//  out_pc       out  PC_W   PC of the entry
//  opcode       out  7      instr[6:0]
//  rd           out  5      instr[11:7]
//  funct3       out  3      instr[14:12]
//  rs1          out  5      instr[19:15]
//  rs2          out  5      instr[24:20]
//  funct7       out  7      instr[31:25]
//  imm          out  XLEN   sign-extended immediate; 0 for R-type or illegal
//  fmt          out  3      format code: R/I/S/B/U/J/NONE (from the package)
//  uses_rs1     out  1      rs1 is a real source operand
//  uses_rs2     out  1      rs2 is a real source operand
//  writes_rd    out  1      rd is written and rd != 0
//  illegal      out  1      unsupported opcode, or instr[1:0] != 2'b11
//  decode_cnt   out  CNT_W  accepted instructions; saturates at all-ones
//  illegal_cnt  out  CNT_W  accepted illegal instructions; saturates
// BEHAVIOUR
//  - Reset (rst_n=0 at the edge): out_valid=0; all field/imm/flag outputs =0;
//    fmt=NONE; counters=0. Reset overrides flush and the handshake.
//  - in_ready = !out_valid || out_ready (combinational; one-entry pipeline).
//  - Accept when in_valid && in_ready: entry is registered on that edge and
//    visible one cycle later. Latency is 1 cycle; throughput is 1 per cycle.
//  - Stall (out_valid && !out_ready): every output is held bit-stable.
//  - If out_valid && out_ready && !in_valid, out_valid falls to 0.
//  - flush=1: out_valid goes to 0 next cycle. An input presented in the same
//    cycle is dropped and not counted. Flush has priority over accept.
//  - Format map: 0110011->R; 0010011, 0000011, 1100111, 1110011->I;
//    0100011->S; 1100011->B; 0110111, 0010111->U; 1101111->J;
//    anything else -> NONE with illegal=1.
//  - Immediates, sign bit instr[31] extended to XLEN:
//    I={i[31:20]}; S={i[31:25],i[11:7]};
//    B={i[31],i[7],i[30:25],i[11:8],0}; U={i[31:12],12'b0};
//    J={i[31],i[19:12],i[20],i[30:21],0}.
//  - uses_rs1: R/I/S/B. uses_rs2: R/S/B. writes_rd: R/I/U/J and rd!=0.
//    All three flags are 0 when illegal=1.
//  - Counters increment on accept only, never on flush-dropped input, and hold
//    at 2^CNT_W-1.
// STRUCTURE
//  - Shared package instr_pkg: opcode localparams, fmt enum codes
//    (FMT_R..FMT_NONE) and an imm_gen function reused by later stages.
//  - One natural combinational sub-module, instr_imm_gen (instr, fmt -> imm),
//    feeding the output register; handshake and counters stay in the top.
// TESTING
//  1 addi x1,x2,-1 (0xFFF10093), out_ready=1 -> next cycle: fmt=I, rd=1,
//    rs1=2, imm=0xFFFFFFFF, writes_rd=1, uses_rs2=0.
//  2 sw x5,8(x2) (0x00512423) -> fmt=S, rs1=2, rs2=5, imm=8, writes_rd=0;
//    then beq x0,x0,-4 (0xFE000EE3) -> fmt=B, imm=0xFFFFFFFC.
//  3 lui x5,0x12345 (0x123452B7) with XLEN=64 -> imm=0x0000000012345000;
//    0xFFF10093 with XLEN=64 -> imm=0xFFFF_FFFF_FFFF_FFFF.
//  4 Back-to-back stream, out_ready low 3 cycles -> in_ready=0, outputs stable,
//    no instruction lost or duplicated; decode_cnt equals instructions sent.
//  5 Instr 0x00000000 -> illegal=1, fmt=NONE, imm=0, illegal_cnt=1; flush with
//    in_valid=1 -> out_valid=0 next cycle, counters unchanged.
//  6 rst_n low mid-stall -> out_valid=0 and counters=0 at the next edge;
//    CNT_W=2, send 5 accepted -> decode_cnt=3 (saturated).

Source files
------------

// File: rtl/instr_pkg.sv
// Shared RV32/RV64 base-ISA decode definitions.
// Opcode map, format codes and the immediate builder used by later stages.
package instr_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       illegal;
  } dec_t;

  localparam dec_t DEC_RST = '{default: '0, fmt: FMT_NONE};

  function automatic fmt_e fmt_of(input logic [6:0] op);
    case (op)
      OP_OP:     fmt_of = FMT_R;
      OP_IMM,
      OP_LOAD,
      OP_JALR,
      OP_SYSTEM: fmt_of = FMT_I;
      OP_STORE:  fmt_of = FMT_S;
      OP_BRANCH: fmt_of = FMT_B;
      OP_LUI,
      OP_AUIPC:  fmt_of = FMT_U;
      OP_JAL:    fmt_of = FMT_J;
      default:   fmt_of = FMT_NONE;
    endcase
  endfunction

  // Result is 32 bits with the sign in bit 31; callers widen it.
  function automatic logic [31:0] imm_gen(
    input logic [31:0] i,
    input fmt_e        f
  );
    case (f)
      FMT_I: imm_gen = {{20{i[31]}}, i[31:20]};
      FMT_S: imm_gen = {{20{i[31]}}, i[31:25], i[11:7]};
      FMT_B: imm_gen = {{19{i[31]}}, i[31], i[7],
                        i[30:25], i[11:8], 1'b0};
      FMT_U: imm_gen = {i[31:12], 12'b0};
      FMT_J: imm_gen = {{11{i[31]}}, i[31], i[19:12],
                        i[20], i[30:21], 1'b0};
      default: imm_gen = '0;
    endcase
  endfunction

endpackage

// File: rtl/instr_imm_gen.sv
// Immediate generator: builds the format immediate and
// sign-extends it to the datapath width.
module instr_imm_gen
  import instr_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  fmt_e            fmt,
  output logic [XLEN-1:0] imm
);

  logic signed [31:0] imm32;
  logic               unused_op;

  assign imm32     = imm_gen(instr, fmt);
  assign imm       = XLEN'(imm32);
  assign unused_op = ^instr[6:0];

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage: fields, immediate, format, register
// usage, one-entry valid/ready buffer, flush and event counters.
module instr_decode_stage
  import instr_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [2:0]       funct3,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       fmt,
  output logic             uses_rs1,
  output logic             uses_rs2,
  output logic             writes_rd,
  output logic             illegal,
  output logic [CNT_W-1:0] decode_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  fmt_e            fmt_raw;
  fmt_e            fmt_d;
  logic            ill_d;
  logic            wr_d;
  dec_t            dec_d;
  dec_t            dec_q;
  logic [XLEN-1:0] imm_d;
  logic            accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    fmt_raw = fmt_of(in_instr[6:0]);
    ill_d   = (fmt_raw == FMT_NONE) ||
              (in_instr[1:0] != 2'b11);
    fmt_d   = ill_d ? FMT_NONE : fmt_raw;
    wr_d    = 1'b0;
    dec_d          = '0;
    dec_d.opcode   = in_instr[6:0];
    dec_d.rd       = in_instr[11:7];
    dec_d.funct3   = in_instr[14:12];
    dec_d.rs1      = in_instr[19:15];
    dec_d.rs2      = in_instr[24:20];
    dec_d.funct7   = in_instr[31:25];
    dec_d.fmt      = fmt_d;
    dec_d.illegal  = ill_d;
    unique case (1'b1)
      ill_d: ;
      fmt_d == FMT_R: begin
        dec_d.uses_rs1 = 1'b1;
        dec_d.uses_rs2 = 1'b1;
        wr_d           = 1'b1;
      end
      fmt_d == FMT_I: begin
        dec_d.uses_rs1 = 1'b1;
        wr_d           = 1'b1;
      end
      fmt_d == FMT_S,
      fmt_d == FMT_B: begin
        dec_d.uses_rs1 = 1'b1;
        dec_d.uses_rs2 = 1'b1;
      end
      fmt_d == FMT_U,
      fmt_d == FMT_J: wr_d = 1'b1;
      default: ;
    endcase
    dec_d.writes_rd = wr_d && (in_instr[11:7] != 5'd0);
  end

  instr_imm_gen #(
    .XLEN (XLEN)
  ) u_imm (
    .instr (in_instr),
    .fmt   (fmt_d),
    .imm   (imm_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      imm         <= '0;
      dec_q       <= DEC_RST;
      decode_cnt  <= '0;
      illegal_cnt <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (in_ready) begin
        out_valid <= in_valid;
      end
      if (accept) begin
        dec_q  <= dec_d;
        imm    <= imm_d;
        out_pc <= in_pc;
        if (decode_cnt != '1) begin
          decode_cnt <= decode_cnt + CNT_W'(1);
        end
        if (ill_d && (illegal_cnt != '1)) begin
          illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign opcode    = dec_q.opcode;
  assign rd        = dec_q.rd;
  assign funct3    = dec_q.funct3;
  assign rs1       = dec_q.rs1;
  assign rs2       = dec_q.rs2;
  assign funct7    = dec_q.funct7;
  assign fmt       = dec_q.fmt;
  assign uses_rs1  = dec_q.uses_rs1;
  assign uses_rs2  = dec_q.uses_rs2;
  assign writes_rd = dec_q.writes_rd;
  assign illegal   = dec_q.illegal;

endmodule
